flash_word_reader: RTL and testbench
====================================

# flash_word_reader

- Read-only adapter between the CPU/bus side and the flash controller.
- Turns one 32-bit word read into two 16-bit flash halfword reads, low half first, and returns the assembled little-endian word with a one-cycle acknowledge.
- Has an optional one-entry last-word buffer so repeated reads of the same word (boot-loader polling, instruction refetch) skip the flash.
- Sits directly upstream of the flash controller: drives its `bus_addr`/`read_op` and consumes its `bus_data_read`.

## Interface
- `FLASH_AW`, 23: flash byte-address width; bit 0 is ignored in 16-bit mode.
- `BUF_EN`, 1: 1 enables the last-word buffer; 0 always goes to flash.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `cpu_req`  in  1  read request; held until `cpu_ack`.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored (word aligned).
- `cpu_busy`  out  1  high whenever state is not IDLE.
- `cpu_ack`  out  1  registered one-cycle pulse; `cpu_rdata` valid in the same cycle.
- `cpu_rdata`  out  32  assembled word; holds its value until the next ack.
- `fc_addr`  out  FLASH_AW  flash byte address to the controller.
- `fc_read_op`  out  1  one-cycle read strobe to the controller.
- `fc_data`  in  32  controller read data; the halfword is duplicated in both halves, so only [15:0] is used.

## Operation
**Controller contract (fixed):**
- `fc_read_op` high in cycle t, with the controller idle, is accepted.
- `fc_data` is valid in cycle t+2.
- The controller is idle again in cycle t+2 and may take a new strobe in that same cycle.
- A strobe in cycle t+1 is ignored, so this block must never issue one.

**Address map:**
- Low half: `fc_addr = {cpu_addr[FLASH_AW-1:2], 2'b00}`.
- High half: `fc_addr = {cpu_addr[FLASH_AW-1:2], 2'b10}`.
- Assembled word: `cpu_rdata = {hi[15:0], lo[15:0]}`.
- `cpu_addr` bits above FLASH_AW-1 are ignored; the decode happens upstream.

**State machine:**
- IDLE
  - `cpu_req && !cpu_ack` and buffer hit (`BUF_EN`, valid, tag == `cpu_addr[FLASH_AW-1:2]`): register `cpu_rdata` from the buffer, pulse `cpu_ack`, stay in IDLE.
  - `cpu_req && !cpu_ack` otherwise: latch the word address and go to LO_REQ.
  - `cpu_req` is ignored in any cycle where `cpu_ack` = 1; this prevents retriggering on a held request.
- LO_REQ: drive `fc_read_op` = 1 with the low address; go to LO_WAIT.
- LO_WAIT: `fc_read_op` = 0; go to LO_CAP.
- LO_CAP: capture `fc_data[15:0]` into the low register; in the same cycle drive `fc_read_op` = 1 with the high address; go to HI_WAIT.
- HI_WAIT: `fc_read_op` = 0; go to HI_CAP.
- HI_CAP:
  - On the edge, register `cpu_rdata = {fc_data[15:0], lo}` and set `cpu_ack` = 1.
  - If `BUF_EN`: load the buffer data/tag and set it valid.
  - Go to IDLE.

**Other rules:**
- `fc_addr` holds its last value when `fc_read_op` = 0; `fc_read_op` is never high in two consecutive cycles.
- `cpu_addr` changes while busy have no effect; the address is latched in IDLE.
- The buffer is never invalidated except by `rst`; flash is read-only through this path.

## Timing
**Reset (on the `clk` edge with `rst` = 1):**
- State returns to IDLE.
- `cpu_ack` = 0, `cpu_busy` = 0, `cpu_rdata` = 0, `fc_read_op` = 0, `fc_addr` = 0.
- Low register = 0, buffer valid = 0.

**Latency:**
- Miss: request seen in IDLE at cycle 0; `fc_read_op` in cycles 1 and 3; `cpu_ack` in cycle 6.
- Back-to-back misses: the next request is accepted in cycle 7 at the earliest, giving 7 cycles per word.
- Hit: request in cycle 0, `cpu_ack` in cycle 1; the next request can be taken in cycle 2.

**Reset mid-transaction:**
- The block aborts and returns to IDLE with no ack.
- A controller response still in flight is ignored, because IDLE never samples `fc_data`.
- A request held across reset is re-accepted in the first cycle after reset and always misses.

## Test plan
- Reset then a miss read of `cpu_addr` 0x0000_0100, with flash half 0x100 = 0x5678 and 0x102 = 0x1234:
  - `fc_read_op` in cycles 1 and 3 with `fc_addr` 0x100 then 0x102.
  - `cpu_ack` in cycle 6 with `cpu_rdata` = 0x1234_5678.
- Repeat the same address (`BUF_EN` = 1): `cpu_ack` at cycle 1, no `fc_read_op`, same data; with `BUF_EN` = 0 the ack comes at cycle 6 via flash.
- Back-to-back misses at 0x0, 0x4, 0x8 with `cpu_req` held high: ack spacing is exactly 7 cycles, no double ack, `fc_read_op` is never high in two consecutive cycles.
- Change `cpu_addr` to 0x200 during LO_WAIT of a read of 0x100: both flash accesses still use 0x100/0x102 and the returned data is for 0x100.
- Assert `rst` during HI_WAIT:
  - No ack; all outputs reach their reset values.
  - The following read of the previously buffered address misses and takes 6 cycles.
- Address aliasing: `cpu_addr` 0xFF80_0102 with FLASH_AW = 23 gives `fc_addr` 0x000100/0x000102; bits [1:0] and upper bits are ignored.

Source files
------------

// File: rtl/flash_word_reader_if.sv
// Bus bundle between the CPU-side requester and flash_word_reader, plus the
// flash-controller side signals that flash_word_reader drives and consumes.
//   cpu_req    requester -> reader  read request, held until cpu_ack
//   cpu_addr   requester -> reader  byte address (bits [1:0] ignored)
//   cpu_busy   reader -> requester  high while a flash access is in progress
//   cpu_ack    reader -> requester  one-cycle acknowledge, cpu_rdata valid with it
//   cpu_rdata  reader -> requester  assembled little-endian word
//   fc_addr    reader -> controller flash byte address
//   fc_read_op reader -> controller one-cycle read strobe
//   fc_data    controller -> reader halfword read data (duplicated in both halves)
interface flash_word_reader_if #(
  parameter int unsigned FLASH_AW = 23
);
  logic                cpu_req;
  logic [31:0]         cpu_addr;
  logic                cpu_busy;
  logic                cpu_ack;
  logic [31:0]         cpu_rdata;
  logic [FLASH_AW-1:0] fc_addr;
  logic                fc_read_op;
  logic [31:0]         fc_data;

  // master: the environment (CPU side and flash controller)
  modport master (
    output cpu_req, cpu_addr, fc_data,
    input  cpu_busy, cpu_ack, cpu_rdata, fc_addr, fc_read_op
  );

  // slave: flash_word_reader itself
  modport slave (
    input  cpu_req, cpu_addr, fc_data,
    output cpu_busy, cpu_ack, cpu_rdata, fc_addr, fc_read_op
  );
endinterface

// File: rtl/flash_word_reader.sv
// Read-only adapter: turns one 32-bit word read into two 16-bit flash halfword
// reads (low half first) and returns the assembled word with a one-cycle ack.
// An optional one-entry last-word buffer lets repeated reads of the same word
// complete in one cycle without touching the flash.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  flash_word_reader_if.slave (cpu_* request/response, fc_* controller side)
// Parameters:
//   FLASH_AW  flash byte-address width
//   BUF_EN    1 enables the last-word buffer
module flash_word_reader #(
  parameter int unsigned FLASH_AW = 23,
  parameter bit          BUF_EN   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  flash_word_reader_if.slave bus
);

  localparam int unsigned WAW = FLASH_AW - 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LO_REQ  = 3'd1;
  localparam logic [2:0] LO_WAIT = 3'd2;
  localparam logic [2:0] LO_CAP  = 3'd3;
  localparam logic [2:0] HI_WAIT = 3'd4;
  localparam logic [2:0] HI_CAP  = 3'd5;

  logic [2:0]     state;
  logic [WAW-1:0] word_addr;
  logic [15:0]    lo_half;
  logic [31:0]    buf_data;
  logic [WAW-1:0] buf_tag;
  logic           buf_valid;
  logic           start;
  logic           hit;

  // A request is ignored in the ack cycle so a held cpu_req cannot retrigger.
  assign start = bus.cpu_req && !bus.cpu_ack;
  assign hit   = BUF_EN && buf_valid && (buf_tag == bus.cpu_addr[FLASH_AW-1:2]);

  assign bus.cpu_busy = (state != IDLE);

  // fc_read_op/fc_addr are registered on the transition into LO_REQ and
  // LO_CAP, so the strobe is visible during exactly those two states and is
  // never high in consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      word_addr      <= '0;
      lo_half        <= '0;
      buf_data       <= '0;
      buf_tag        <= '0;
      buf_valid      <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.fc_read_op <= 1'b0;
      bus.fc_addr    <= '0;
    end else begin
      bus.cpu_ack    <= 1'b0;
      bus.fc_read_op <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (hit) begin
              bus.cpu_rdata <= buf_data;
              bus.cpu_ack   <= 1'b1;
            end else begin
              word_addr      <= bus.cpu_addr[FLASH_AW-1:2];
              bus.fc_addr    <= {bus.cpu_addr[FLASH_AW-1:2], 2'b00};
              bus.fc_read_op <= 1'b1;
              state          <= LO_REQ;
            end
          end
        end
        LO_REQ: begin
          state <= LO_WAIT;
        end
        LO_WAIT: begin
          bus.fc_addr    <= {word_addr, 2'b10};
          bus.fc_read_op <= 1'b1;
          state          <= LO_CAP;
        end
        LO_CAP: begin
          lo_half <= bus.fc_data[15:0];
          state   <= HI_WAIT;
        end
        HI_WAIT: begin
          state <= HI_CAP;
        end
        HI_CAP: begin
          bus.cpu_rdata <= {bus.fc_data[15:0], lo_half};
          bus.cpu_ack   <= 1'b1;
          if (BUF_EN) begin
            buf_data  <= {bus.fc_data[15:0], lo_half};
            buf_tag   <= word_addr;
            buf_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_word_reader.sv
// Self-checking bench for flash_word_reader: one instance with the last-word
// buffer and one without, driven with identical stimulus; each is checked
// against a word-level reference model and a flash controller model.
module tb_flash_word_reader;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic        req_b;
  logic [31:0] addr_v;

  flash_word_reader_if #(.FLASH_AW(23)) bus_a ();
  flash_word_reader_if #(.FLASH_AW(23)) bus_b ();

  flash_word_reader #(.FLASH_AW(23), .BUF_EN(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  flash_word_reader #(.FLASH_AW(23), .BUF_EN(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_a.cpu_req  = req_a;
  assign bus_a.cpu_addr = addr_v;
  assign bus_b.cpu_req  = req_b;
  assign bus_b.cpu_addr = addr_v;

  // Flash contents: two fixed halfwords, everything else a hash of the address.
  function automatic logic [15:0] half(input logic [22:0] a);
    logic [15:0] h;
    if (a == 23'h000100) return 16'h5678;
    if (a == 23'h000102) return 16'h1234;
    h = a[15:0] * 16'd40503;
    return h ^ 16'h1F2E;
  endfunction

  // Reference word for a CPU byte address: little-endian pair of halfwords.
  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [20:0] w;
    w = addr[22:2];
    return {half({w, 2'b10}), half({w, 2'b00})};
  endfunction

  // Flash controller model: data valid exactly two cycles after the strobe.
  logic        p1a = 1'b0, p2a = 1'b0, p1b = 1'b0, p2b = 1'b0;
  logic [22:0] a1a, a2a, a1b, a2b;
  always @(posedge clk) begin
    p1a <= bus_a.fc_read_op; a1a <= bus_a.fc_addr; p2a <= p1a; a2a <= a1a;
    p1b <= bus_b.fc_read_op; a1b <= bus_b.fc_addr; p2b <= p1b; a2b <= a1b;
  end
  assign bus_a.fc_data = p2a ? {2{half(a2a)}} : 32'hDEAD_BEEF;
  assign bus_b.fc_data = p2b ? {2{half(a2b)}} : 32'hDEAD_BEEF;

  // Cycle-indexed event log, sampled at the active edge (values of the cycle ending).
  int          cyc = 0;
  int          stc_a[$], stc_b[$], ackc_a[$], ackc_b[$];
  logic [22:0] sta_a[$], sta_b[$];
  logic [31:0] ackd_a[$], ackd_b[$];
  int          busy_a = 0, busy_b = 0;
  int          dbl_a = 0, dbl_b = 0;
  bit          prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge clk) begin
    if (bus_a.fc_read_op === 1'b1) begin
      stc_a.push_back(cyc); sta_a.push_back(bus_a.fc_addr);
      if (prev_a) dbl_a++;
    end
    if (bus_b.fc_read_op === 1'b1) begin
      stc_b.push_back(cyc); sta_b.push_back(bus_b.fc_addr);
      if (prev_b) dbl_b++;
    end
    prev_a = (bus_a.fc_read_op === 1'b1);
    prev_b = (bus_b.fc_read_op === 1'b1);
    if (bus_a.cpu_ack === 1'b1) begin ackc_a.push_back(cyc); ackd_a.push_back(bus_a.cpu_rdata); end
    if (bus_b.cpu_ack === 1'b1) begin ackc_b.push_back(cyc); ackd_b.push_back(bus_b.cpu_rdata); end
    if (bus_a.cpu_busy === 1'b1) busy_a++;
    if (bus_b.cpu_busy === 1'b1) busy_b++;
    cyc = cyc + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference buffer state for the BUF_EN=1 instance.
  bit          bvalid = 1'b0;
  logic [20:0] btag   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    stc_a.delete(); sta_a.delete(); ackc_a.delete(); ackd_a.delete();
    stc_b.delete(); sta_b.delete(); ackc_b.delete(); ackd_b.delete();
    busy_a = 0; busy_b = 0;
  endtask

  task automatic check_reset(input string tag, input int d);
    if (d == 0) begin
      check({tag, " ack"},     64'(bus_a.cpu_ack),    0);
      check({tag, " busy"},    64'(bus_a.cpu_busy),   0);
      check({tag, " rdata"},   64'(bus_a.cpu_rdata),  0);
      check({tag, " read_op"}, 64'(bus_a.fc_read_op), 0);
      check({tag, " fc_addr"}, 64'(bus_a.fc_addr),    0);
    end else begin
      check({tag, " ack"},     64'(bus_b.cpu_ack),    0);
      check({tag, " busy"},    64'(bus_b.cpu_busy),   0);
      check({tag, " rdata"},   64'(bus_b.cpu_rdata),  0);
      check({tag, " read_op"}, 64'(bus_b.fc_read_op), 0);
      check({tag, " fc_addr"}, 64'(bus_b.fc_addr),    0);
    end
  endtask

  // One word read: exactly one ack at k+lat with wexp; two strobes at k+1/k+3
  // for a flash access, none for a buffer hit.
  task automatic check_txn(input string tag, input int d, input int k, input int lat,
                           input logic [31:0] wexp, input logic [22:0] alo, input bit flash);
    int          ac[$];
    int          sc[$];
    logic [31:0] ad[$];
    logic [22:0] sa[$];
    int          bz;
    if (d == 0) begin ac = ackc_a; ad = ackd_a; sc = stc_a; sa = sta_a; bz = busy_a; end
    else        begin ac = ackc_b; ad = ackd_b; sc = stc_b; sa = sta_b; bz = busy_b; end
    check({tag, " ack_count"}, 64'(ac.size()), 1);
    if (ac.size() >= 1) begin
      check({tag, " ack_cycle"}, 64'(ac[0] - k), 64'(lat));
      check({tag, " rdata"},     64'(ad[0]),     64'(wexp));
    end
    if (flash) begin
      check({tag, " strobe_count"}, 64'(sc.size()), 2);
      if (sc.size() == 2) begin
        check({tag, " lo_strobe_cycle"}, 64'(sc[0] - k), 1);
        check({tag, " hi_strobe_cycle"}, 64'(sc[1] - k), 3);
        check({tag, " lo_addr"},         64'(sa[0]),     64'(alo));
        check({tag, " hi_addr"},         64'(sa[1]),     64'(alo | 23'h2));
      end
      check({tag, " busy_cycles"}, 64'(bz), 5);
    end else begin
      check({tag, " strobe_count"}, 64'(sc.size()), 0);
      check({tag, " busy_cycles"},  64'(bz), 0);
    end
  endtask

  // Read of addr; optionally change cpu_addr to chg_addr in cycle chg_n.
  task automatic run_read(input string tag, input logic [31:0] addr,
                          input int chg_n, input logic [31:0] chg_addr);
    int          k;
    bit          hit;
    int          lat_a;
    logic [31:0] w;
    logic [22:0] alo;
    w     = exp_word(addr);
    alo   = {addr[22:2], 2'b00};
    hit   = bvalid && (btag == addr[22:2]);
    lat_a = hit ? 1 : 6;
    clear_logs();
    k      = cyc;
    addr_v = addr;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == chg_n) addr_v = chg_addr;
      if (n == lat_a) req_a = 1'b0;
      if (n == 6)     req_b = 1'b0;
    end
    check_txn({tag, " bufA"},   0, k, lat_a, w, alo, !hit);
    check_txn({tag, " nobufB"}, 1, k, 6,     w, alo, 1'b1);
    bvalid = 1'b1;
    btag   = addr[22:2];
  endtask

  task automatic check_b2b(input string tag, input int d, input int k);
    int          ac[$];
    int          sc[$];
    logic [31:0] ad[$];
    logic [22:0] sa[$];
    if (d == 0) begin ac = ackc_a; ad = ackd_a; sc = stc_a; sa = sta_a; end
    else        begin ac = ackc_b; ad = ackd_b; sc = stc_b; sa = sta_b; end
    check({tag, " ack_count"},    64'(ac.size()), 3);
    check({tag, " strobe_count"}, 64'(sc.size()), 6);
    for (int i = 0; i < 3; i++) begin
      if (ac.size() > i) begin
        check({tag, " ack_cycle"}, 64'(ac[i] - k), 64'(6 + 7 * i));
        check({tag, " rdata"},     64'(ad[i]),     64'(exp_word(32'(4 * i))));
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (sc.size() > i) begin
        check({tag, " strobe_cycle"}, 64'(sc[i] - k), 64'(1 + 7 * (i / 2) + 2 * (i % 2)));
        check({tag, " strobe_addr"},  64'(sa[i]),     64'(2 * i));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] pool [4];

  initial begin
    int k;
    rst    = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    addr_v = '0;
    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0004;
    pool[2] = 32'h007F_FFFC; pool[3] = 32'h0000_02A8;

    repeat (2) @(negedge clk);
    check_reset("reset A", 0);
    check_reset("reset B", 1);
    rst = 1'b0;
    @(negedge clk);

    // First miss, then the same word again (hit only with the buffer).
    run_read("miss 0x100", 32'h0000_0100, 0, 32'h0);
    run_read("repeat 0x100", 32'h0000_0100, 0, 32'h0);

    // Back-to-back misses with cpu_req held high throughout.
    clear_logs();
    k      = cyc;
    addr_v = 32'h0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 6)  addr_v = 32'h4;
      if (n == 13) addr_v = 32'h8;
      if (n == 20) begin req_a = 1'b0; req_b = 1'b0; end
    end
    check_b2b("b2b A", 0, k);
    check_b2b("b2b B", 1, k);
    bvalid = 1'b1;
    btag   = 21'h2;

    // cpu_addr moves during LO_WAIT; the latched address must be used.
    run_read("pre 0x40", 32'h0000_0040, 0, 32'h0);
    run_read("addr change", 32'h0000_0100, 2, 32'h0000_0200);

    // Reset during HI_WAIT of a miss: no ack, reset outputs, buffer cleared.
    run_read("buffer 0x8", 32'h0000_0008, 0, 32'h0);
    clear_logs();
    k      = cyc;
    addr_v = 32'h0000_0100;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int n = 1; n <= 4; n++) @(negedge clk);
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midreset A", 0);
    check_reset("midreset B", 1);
    repeat (4) @(negedge clk);
    check("midreset A ack_count", 64'(ackc_a.size()), 0);
    check("midreset B ack_count", 64'(ackc_b.size()), 0);
    bvalid = 1'b0;
    run_read("after reset 0x8", 32'h0000_0008, 0, 32'h0);

    // Upper address bits and bits [1:0] are ignored.
    run_read("alias FF800102", 32'hFF80_0102, 0, 32'h0);
    run_read("alias 00000101", 32'h0000_0101, 0, 32'h0);

    // Random reads from a small pool so both hits and misses occur.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = (32'($urandom) & 32'hFF80_0003) | pool[$urandom_range(0, 3)];
      run_read($sformatf("rand%0d", i), a, int'($urandom_range(0, 5)), 32'($urandom));
    end

    check("A consecutive strobes", 64'(dbl_a), 0);
    check("B consecutive strobes", 64'(dbl_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
